ser_rr_scheduler: RTL and testbench
===================================

Name: ser_rr_scheduler

Overview:
Shares one LSB-first parallel-to-serial shifter among NUM_REQ requesters using round-robin arbitration. Each requester presents a DATA_W-bit word with a valid/ready handshake. The scheduler grants one requester, loads its word and shifts it out one bit per cycle, tagging the stream with start-of-word and channel id. Words are emitted back-to-back, with no idle bubble, while requests are pending. The block sits between the per-channel producers and the single serial link.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 4, bits per word (2..32)
CH_W, $clog2(NUM_REQ), channel-id width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester word valid; must be held until accepted
req_data_i  in  NUM_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W]
req_ready_o  out  NUM_REQ  one-hot accept; the word transfers when valid and ready are both high
serial_o  out  1  serial data, LSB first
valid_o  out  1  serial_o carries a data bit this cycle
sop_o  out  1  first bit of a word
chan_o  out  CH_W  id of the requester whose word is on serial_o
busy_o  out  1  shifter is occupied (equals valid_o)

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. All registered outputs go to 0: serial_o, valid_o, sop_o, chan_o, busy_o. The shift register and bit counter go to 0. State is IDLE. last_grant resets to NUM_REQ-1, so channel 0 has highest priority first.
- FSM has two states: IDLE and SHIFT.
- Accept window: IDLE, or SHIFT with bit_cnt == DATA_W-1 (last bit on the wire).
- In an accept window with any req_valid_i set:
  - Round-robin picks the first valid requester, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready_o[g] = 1 combinationally that cycle; all other ready bits are 0.
  - On the next edge: shift register <= word g; bit_cnt <= 0; chan reg <= g; last_grant <= g; state <= SHIFT.
- Outside an accept window, req_ready_o is all 0.
- req_ready_o may depend on req_valid_i. Requesters must not make valid depend on ready.
- Output timing in SHIFT:
  - serial_o = shift[0], valid_o = 1, chan_o = granted id.
  - sop_o = 1 only when bit_cnt == 0.
  - Each edge: shift right (0 fills the MSB) and bit_cnt increments.
- Latency: word accepted in cycle T gives bit0 at T+1 and the last bit at T+DATA_W. The next accept can occur in cycle T+DATA_W, so words run continuously.
- End of word: at bit_cnt == DATA_W-1, go to SHIFT with the new word if a grant occurs, else go to IDLE. In IDLE, valid_o = sop_o = 0 and serial_o = 0; chan_o holds its last value.
- last_grant updates only on an actual grant. Idle cycles do not advance the pointer.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0…
- bit_cnt width is $clog2(DATA_W). Compare against DATA_W-1 exactly; no wrap past DATA_W-1.
- Reset mid-word: the remaining bits are dropped; no further valid_o; the pointer returns to its reset value. The requester whose word was in flight is not re-requested by this block.
- A requester whose valid drops before it is granted is simply skipped; this is a protocol violation, but nothing in the block locks up.

Decomposition:
- Package ser_sched_pkg holds:
  - state enum (IDLE, SHIFT);
  - localparam helper for CH_W;
  - function rr_pick(valid, last_grant), returning grant index plus an any-valid flag.
- One sub-module, rr_arbiter (parameter NUM_REQ). It is combinational: it takes the request vector and the last_grant pointer and returns a one-hot grant and an encoded index. The pointer register stays in ser_rr_scheduler.

Test Plan:
1. NUM_REQ=4, DATA_W=4. Only req0 valid with 4'hA at T. Expect ready[0]=1 at T; serial 0,1,0,1 at T+1..T+4; sop at T+1 only; chan_o=0; IDLE at T+5.
2. req1=4'h3 and req2=4'hC raised in the same cycle from reset. Expect req1 granted first (bits 1,1,0,0), then req2 back-to-back (bits 0,0,1,1). valid_o stays high for 8 consecutive cycles; sop in cycles 1 and 5.
3. All four requesters held valid for 16 words. Grant order is 0,1,2,3 repeated; valid_o never drops; each requester gets exactly 4 grants.
4. After granting req3, only req0 and req3 are valid. Next grant is req0, then req3. Checks wrap of the pointer.
5. Assert reset in the cycle showing bit 2 of a word. All outputs are 0 the same cycle; no stale bits after release. The first grant after release goes to the lowest valid index.
6. req2 valid alone for one word, then 3 idle cycles, then req2 again. Second grant is req2. The pointer did not advance while idle.

Source files
------------

// File: rtl/ser_sched_pkg.sv
// Shared types, state encodings and the round-robin pick function for the
// serial round-robin scheduler.
package ser_sched_pkg;

  localparam int unsigned MaxReq = 16;

  typedef logic [0:0] state_t;
  localparam state_t StIdle  = 1'b0;
  localparam state_t StShift = 1'b1;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } pick_t;

  function automatic int unsigned ch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First valid requester searching upward from last_grant+1, wrapping at num_req.
  function automatic pick_t rr_pick(logic [MaxReq-1:0] valid, logic [3:0] last_grant,
                                    int unsigned num_req);
    pick_t       p;
    int unsigned c;
    p = '0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      if (i <= num_req) begin
        c = 32'(last_grant) + i;
        if (c >= num_req) c = c - num_req;
        if (!p.any && valid[c[3:0]]) begin
          p.any = 1'b1;
          p.idx = c[3:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ser_rr_scheduler_if.sv
// Requester handshake and serial link bundle of the serial round-robin scheduler.
interface ser_rr_scheduler_if
  import ser_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  localparam int unsigned CH_W   = ch_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      serial_o;
  logic                      valid_o;
  logic                      sop_o;
  logic [CH_W-1:0]           chan_o;
  logic                      busy_o;

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, serial_o, valid_o, sop_o, chan_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, serial_o, valid_o, sop_o, chan_o, busy_o
  );
endinterface

// File: rtl/ser_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index.
module rr_arbiter
  import ser_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned CH_W   = ch_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [CH_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [CH_W-1:0]    grant_idx,
  output logic               any
);
  pick_t pick;

  always_comb begin
    pick      = rr_pick(MaxReq'(req), 4'(last_grant), NUM_REQ);
    any       = pick.any;
    grant_idx = pick.idx[CH_W-1:0];
    grant     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      grant[k] = pick.any && (pick.idx == 4'(k));
    end
  end
endmodule

// File: rtl/ser_rr_scheduler.sv
// Round-robin scheduler sharing one LSB-first shifter among NUM_REQ requesters;
// words run back-to-back by accepting the next word on the last bit.
module ser_rr_scheduler
  import ser_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  localparam int unsigned CH_W   = ch_width(NUM_REQ)
) (
  input logic               clk,
  input logic               reset,
  ser_rr_scheduler_if.slave bus
);
  localparam int unsigned       CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0]   LastBit = CntW'(DATA_W - 1);

  state_t              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [CntW-1:0]     cnt_q;
  logic [CH_W-1:0]     chan_q;
  logic [CH_W-1:0]     last_q;

  logic [NUM_REQ-1:0]  grant;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_any;
  logic                last_bit;
  logic                take;
  logic [DATA_W-1:0]   word;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (bus.req_valid_i),
    .last_grant(last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    last_bit        = (cnt_q == LastBit);
    take            = ((state_q == StIdle) || last_bit) && grant_any;
    bus.req_ready_o = take ? grant : '0;
    word            = bus.req_data_i[grant_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      chan_q  <= '0;
      last_q  <= CH_W'(NUM_REQ - 1);
    end else if (take) begin
      state_q <= StShift;
      shift_q <= word;
      cnt_q   <= '0;
      chan_q  <= grant_idx;
      last_q  <= grant_idx;
    end else if (state_q == StShift) begin
      if (last_bit) begin
        state_q <= StIdle;
      end else begin
        shift_q <= shift_q >> 1;
        cnt_q   <= cnt_q + CntW'(1);
      end
    end
  end

  assign bus.valid_o  = (state_q == StShift);
  assign bus.serial_o = bus.valid_o & shift_q[0];
  assign bus.sop_o    = bus.valid_o && (cnt_q == '0);
  assign bus.chan_o   = chan_q;
  assign bus.busy_o   = bus.valid_o;
endmodule

// File: tb/tb_ser_rr_scheduler.sv
// Directed scoreboard bench for ser_rr_scheduler (NUM_REQ=4, DATA_W=4).
module tb_ser_rr_scheduler;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [1:0] chan;
    logic       bit_v;
    logic       sop;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ser_rr_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  ser_rr_scheduler #(
    .NUM_REQ(NR),
    .DATA_W (DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t          expq[$];
  logic [DW-1:0] wq[NR][$];
  logic [NR-1:0] acc;
  int            checks = 0;
  int            errors = 0;
  int            run_len = 0;
  int            max_run = 0;
  int            sop_cnt[NR];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(int ch, logic [DW-1:0] w);
    for (int b = 0; b < DW; b++) expq.push_back('{chan: 2'(ch), bit_v: w[b], sop: (b == 0)});
  endtask

  task automatic push_req(int ch, logic [DW-1:0] w);
    wq[ch].push_back(w);
  endtask

  task automatic clear_stats();
    max_run = 0;
    for (int k = 0; k < NR; k++) sop_cnt[k] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    clear_stats();
  endtask

  task automatic wait_drain(string tag, int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      done = (expq.size() == 0) && !bus.valid_o &&
             (wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size() == 0);
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic wait_sop(string tag, int ch, int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus.valid_o && bus.sop_o && (bus.chan_o == 2'(ch));
    end
    check({tag, "_sop_seen"}, 32'(seen), 32'd1);
  endtask

  // Requester model: holds valid while its queue has words, pops on accept.
  always @(negedge clk) acc = reset ? '0 : (bus.req_valid_i & bus.req_ready_o);

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < NR; k++) begin
      if (acc[k] && wq[k].size() != 0) wq[k].delete(0);
      bus.req_valid_i[k] = (wq[k].size() != 0);
      bus.req_data_i[k*DW +: DW] = (wq[k].size() != 0) ? wq[k][0] : '0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run_len = 0;
    end else begin
      check("ready_subset_valid", 32'(bus.req_ready_o & ~bus.req_valid_i), 32'd0);
      if (bus.valid_o) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        checks++;
        assert (expq.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_bit observed chan=%0d serial=%0b expected no bit",
                 bus.chan_o, bus.serial_o);
        end
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("serial", 32'(bus.serial_o), 32'(e.bit_v));
          check("sop", 32'(bus.sop_o), 32'(e.sop));
          check("chan", 32'(bus.chan_o), 32'(e.chan));
          check("busy", 32'(bus.busy_o), 32'd1);
        end
        if (bus.sop_o) sop_cnt[bus.chan_o]++;
      end else begin
        run_len = 0;
        check("idle_serial", 32'(bus.serial_o), 32'd0);
        check("idle_sop", 32'(bus.sop_o), 32'd0);
        check("idle_busy", 32'(bus.busy_o), 32'd0);
      end
    end
  end

  initial begin
    logic [DW-1:0] w;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    clear_stats();

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_serial", 32'(bus.serial_o), 32'd0);
    check("rst_sop", 32'(bus.sop_o), 32'd0);
    check("rst_chan", 32'(bus.chan_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: single word from req0
    @(posedge clk); #1;
    push_exp(0, 4'hA); push_req(0, 4'hA);
    @(negedge clk);
    check("t1_ready", 32'(bus.req_ready_o), 32'b0001);
    wait_drain("t1", 20);
    check("t1_run", 32'(max_run), 32'd4);
    check("t1_idle", 32'(bus.valid_o), 32'd0);

    // 2: req1 and req2 together from reset, back-to-back
    do_reset();
    @(posedge clk); #1;
    push_exp(1, 4'h3); push_exp(2, 4'hC);
    push_req(1, 4'h3); push_req(2, 4'hC);
    wait_drain("t2", 30);
    check("t2_run", 32'(max_run), 32'd8);
    check("t2_sop1", 32'(sop_cnt[1]), 32'd1);
    check("t2_sop2", 32'(sop_cnt[2]), 32'd1);

    // 3: all four continuously valid for 16 words
    do_reset();
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NR; c++) begin
        w = 4'($urandom_range(0, 15));
        push_exp(c, w); push_req(c, w);
      end
    end
    wait_drain("t3", 200);
    check("t3_run", 32'(max_run), 32'd64);
    for (int c = 0; c < NR; c++) check("t3_grants", 32'(sop_cnt[c]), 32'd4);

    // 4: pointer wrap; req0 joins while req3 still has a word pending
    clear_stats();
    @(posedge clk); #1;
    push_exp(3, 4'h6); push_exp(0, 4'h9); push_exp(3, 4'hE);
    push_req(3, 4'h6); push_req(3, 4'hE);
    wait_sop("t4", 3, 20);
    @(posedge clk); #1;
    push_req(0, 4'h9);
    wait_drain("t4", 40);
    check("t4_run", 32'(max_run), 32'd12);

    // 5: reset while bit 2 of a word is on the wire
    clear_stats();
    @(posedge clk); #1;
    push_exp(1, 4'h5); push_req(1, 4'h5);
    wait_sop("t5", 1, 20);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("t5_valid", 32'(bus.valid_o), 32'd0);
    check("t5_serial", 32'(bus.serial_o), 32'd0);
    check("t5_sop", 32'(bus.sop_o), 32'd0);
    check("t5_chan", 32'(bus.chan_o), 32'd0);
    check("t5_busy", 32'(bus.busy_o), 32'd0);
    check("t5_dropped_bits", 32'(expq.size()), 32'd2);
    expq.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_exp(0, 4'h7); push_exp(2, 4'hB);
    push_req(0, 4'h7); push_req(2, 4'hB);
    wait_drain("t5", 30);

    // 6: idle cycles must not advance the pointer
    @(posedge clk); #1;
    push_exp(2, 4'h1); push_req(2, 4'h1);
    wait_drain("t6a", 20);
    repeat (3) @(posedge clk);
    #1;
    push_exp(2, 4'h8); push_req(2, 4'h8);
    wait_drain("t6b", 20);
    repeat (3) @(posedge clk);
    #1;
    push_exp(1, 4'hD); push_exp(2, 4'h2);
    push_req(1, 4'hD); push_req(2, 4'h2);
    wait_drain("t6c", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
